uart_mmio_fifo: RTL and testbench
=================================

Name: uart_mmio_fifo

Overview:
Memory-mapped full-duplex UART peripheral for the SOC IO page. It replaces the transmit-only emitter with parametrised TX and RX FIFOs, an 8N1 receiver, sticky error flags and an interrupt output. It is selected by the SOC address decode and exposes four word registers on the processor's mem_* bus.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency
BAUD_RATE, 1000000, line rate; DIV = CLK_FREQ_HZ/BAUD_RATE (integer, must be ≥4)
TX_DEPTH, 16, TX FIFO entries (power of 2, ≥2)
RX_DEPTH, 16, RX FIFO entries (power of 2, ≥2)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous reset, active-low
sel  in  1  chip select from SOC decode
addr  in  2  word offset within block
wdata  in  32  write data
wmask  in  4  byte write mask; a write occurs when sel & wmask[0]
rstrb  in  1  read strobe
rdata  out  32  registered read data
txd  out  1  serial out, idle high
rxd  in  1  serial in, asynchronous
irq  out  1  level interrupt, registered

Behaviour:
- Reset (async, resetn=0): FIFOs empty, sticky flags 0, CTRL 0, rdata 0, irq 0, txd 1, TX/RX FSMs IDLE, rxd synchroniser flops set to 1. Reset mid-frame aborts the frame; txd goes to 1 immediately.
- Reads: when sel & rstrb, rdata updates at the next edge (1-cycle latency). Otherwise rdata holds its value.
- Register map:
  - 0 DATA. Write pushes wdata[7:0]; if the TX FIFO is full the byte is dropped and tx_ovf is set. Read returns {23'b0, valid, byte}; it pops the RX FIFO only if non-empty, otherwise it returns 0.
  - 1 STATUS. bit0 rx_valid, bit1 tx_full, bit2 tx_idle (FIFO empty and shifter idle), bit3 rx_ovf, bit4 frame_err, bit5 tx_ovf, bit9 tx_full (legacy busy bit), other bits 0. Write is W1C on bits 3–5.
  - 2 CTRL. bit0 rx_irq_en, bit1 tx_irq_en, bit2 loopback (optional feature); R/W.
  - 3 LEVEL. [15:0] RX count, [31:16] TX count; read-only.
- Writes with wmask[0]=0 are ignored.
- FIFO rules:
  - Push and pop in the same cycle on a full FIFO: both succeed.
  - Push and pop in the same cycle on an empty FIFO: pop reports empty, push succeeds.
  - Pointers wrap modulo depth; count width is clog2(depth)+1.
- TX FSM (IDLE→START→DATA→STOP):
  - In IDLE with the FIFO non-empty: pop into the shifter at the next edge.
  - Frame: start 0, 8 data bits LSB first, stop 1, each DIV cycles (10·DIV cycles total).
  - After STOP, if the FIFO is non-empty, the next START follows with no idle gap beyond the single pop cycle.
- RX FSM (IDLE→START→DATA→STOP):
  - rxd passes through a 2-flop synchroniser.
  - IDLE detects a falling edge on the synchronised line.
  - START samples at DIV/2; a 1 there is a false start and returns to IDLE.
  - DATA samples 8 bits at DIV intervals.
  - STOP samples after DIV. Stop=1 pushes the byte (if the FIFO is full the byte is dropped and rx_ovf is set). Stop=0 discards the byte and sets frame_err.
  - Return to IDLE; a new frame requires a fresh high→low edge.
- irq: registered each cycle as (rx_irq_en & rx_valid) | (tx_irq_en & TX FIFO empty).

Optional Feature:
UART_LOOPBACK_EN:
- Defined: CTRL bit2 is R/W. When set, the internal TX serial line feeds the RX synchroniser input and txd is held at 1.
- Undefined: CTRL bit2 reads 0 and writes are ignored; rxd is always used.

Decomposition:
- Shared package/include: register offsets (DATA/STATUS/CTRL/LEVEL), STATUS and CTRL bit positions, FSM state encodings.
- One sub-module: uart_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count), instantiated twice.

Test Plan (CLK_FREQ_HZ=8, BAUD_RATE=1 → DIV=8):
1. Write DATA=0x55 → txd low for 8 cycles, then data 1,0,1,0,1,0,1,0 at 8 cycles each, stop high. STATUS bit2 reads 1 after 80 cycles.
2. Write 0x00, wait 2 cycles, write 0x01..0x11 back-to-back → 0x11 dropped. STATUS reads bit5=1, bit1=bit9=1, LEVEL[31:16]=16. txd emits 0x00..0x10 in order.
3. Drive an rxd frame of 0xA3 → DATA reads 0x1A3; a second read returns 0x000. With CTRL=0x1, irq=1 while the byte is pending.
4. Drive a 2-cycle rxd low glitch → nothing pushed. Drive a frame with stop=0 → STATUS bit4=1 and RX empty; write STATUS=0x10 → bit4=0.
5. Receive 17 frames 0x00..0x10 without reading → STATUS bit3=1; 16 reads return 0x100..0x10F.
6. Pull resetn low at the 4th TX bit → txd=1 immediately; afterwards STATUS=0x004, LEVEL=0. With UART_LOOPBACK_EN, CTRL=0x4, write 0x3C → DATA reads 0x13C and txd stays 1.

Source files
------------

// File: rtl/uart_mmio_fifo_pkg.sv
// uart_mmio_fifo_pkg: register offsets, STATUS/CTRL bit positions and FSM states of the UART.
package uart_mmio_fifo_pkg;
  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_LEVEL = 2'd3;
  localparam int ST_RX_VALID = 0, ST_TX_FULL = 1, ST_TX_IDLE = 2, ST_RX_OVF = 3;
  localparam int ST_FRAME_ERR = 4, ST_TX_OVF = 5, ST_BUSY = 9;
  localparam int CT_RX_IRQ = 0, CT_TX_IRQ = 1, CT_LOOPBACK = 2;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;
endpackage

// File: rtl/uart_mmio_fifo_fifo.sv
// uart_sync_fifo: synchronous FIFO; a pop on empty is ignored, push+pop on full both succeed.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign rdata = mem[rp];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/uart_mmio_fifo.sv
// uart_mmio_fifo: MMIO 8N1 UART with TX/RX FIFOs, sticky errors and irq; UART_LOOPBACK_EN adds CTRL loopback.
module uart_mmio_fifo
  import uart_mmio_fifo_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE = 1000000,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        rstrb,
  output logic [31:0] rdata,
  output logic        txd,
  input  logic        rxd,
  output logic        irq
);
  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;
  logic wr, rd, st_wr, tx_push, tx_pop, tx_full, tx_empty, rx_pop, rx_full, rx_empty;
  logic [7:0] tx_dout, rx_dout, tx_sh, rx_sh;
  logic [TCW-1:0] tx_count;
  logic [RCW-1:0] rx_count;
  logic [2:0] ctrl, ctrl_wr, tx_bit, rx_bit;
  logic rx_ovf, frame_err, tx_ovf, tx_line, rx_in, rx_s1, rx_s2, rx_prev;
  logic rx_push, rx_ferr, tx_tick, rx_tick, rx_half, unused_bits;
  logic [31:0] status, rd_val;
  logic [CW-1:0] tx_cnt, rx_cnt;
  uart_state_e tx_st, tx_nxt, rx_st, rx_nxt;
  assign wr = sel & wmask[0];
  assign rd = sel & rstrb;
  assign st_wr = wr && addr == A_STATUS;
  assign tx_push = wr && addr == A_DATA;
  assign rx_pop = rd && addr == A_DATA && !rx_empty;
  assign unused_bits = ^{wdata[31:8], wmask[3:1]};
`ifdef UART_LOOPBACK_EN
  assign ctrl_wr = wdata[2:0];
  assign rx_in = ctrl[CT_LOOPBACK] ? tx_line : rxd;
  assign txd = ctrl[CT_LOOPBACK] | tx_line;
`else
  assign ctrl_wr = {1'b0, wdata[1:0]};
  assign rx_in = rxd;
  assign txd = tx_line;
`endif
  uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .resetn(resetn), .push(tx_push), .pop(tx_pop), .wdata(wdata[7:0]),
    .rdata(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
  uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .resetn(resetn), .push(rx_push), .pop(rx_pop), .wdata(rx_sh),
    .rdata(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
  assign tx_tick = tx_cnt == LAST;
  assign tx_line = tx_st == S_START ? 1'b0 : tx_st == S_DATA ? tx_sh[0] : 1'b1;
  always_comb begin
    tx_nxt = tx_st;
    tx_pop = 1'b0;
    case (tx_st)
      S_IDLE: if (!tx_empty) begin
        tx_pop = 1'b1;
        tx_nxt = S_START;
      end
      S_START: if (tx_tick) tx_nxt = S_DATA;
      S_DATA: if (tx_tick && tx_bit == 3'd7) tx_nxt = S_STOP;
      default: if (tx_tick) tx_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      tx_st <= S_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
    end else begin
      tx_st <= tx_nxt;
      tx_cnt <= (tx_st == S_IDLE || tx_tick) ? '0 : tx_cnt + CW'(1);
      tx_bit <= tx_st != S_DATA ? '0 : tx_tick ? tx_bit + 3'd1 : tx_bit;
      if (tx_pop) tx_sh <= tx_dout;
      else if (tx_st == S_DATA && tx_tick) tx_sh <= tx_sh >> 1;
    end
  // rx_prev trails the synchronised line so IDLE only starts on a genuine high->low edge
  assign rx_tick = rx_cnt == LAST;
  assign rx_half = rx_cnt == HALF;
  always_comb begin
    rx_nxt = rx_st;
    rx_push = 1'b0;
    rx_ferr = 1'b0;
    case (rx_st)
      S_IDLE: if (rx_prev && !rx_s2) rx_nxt = S_START;
      S_START: if (rx_half) rx_nxt = rx_s2 ? S_IDLE : S_DATA;
      S_DATA: if (rx_tick && rx_bit == 3'd7) rx_nxt = S_STOP;
      default: if (rx_tick) begin
        rx_nxt = S_IDLE;
        rx_push = rx_s2;
        rx_ferr = !rx_s2;
      end
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_prev <= 1'b1;
      rx_st <= S_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
    end else begin
      rx_s1 <= rx_in;
      rx_s2 <= rx_s1;
      rx_prev <= rx_s2;
      rx_st <= rx_nxt;
      rx_cnt <= (rx_st == S_IDLE || rx_tick || (rx_st == S_START && rx_half)) ? '0 : rx_cnt + CW'(1);
      rx_bit <= rx_st != S_DATA ? '0 : rx_tick ? rx_bit + 3'd1 : rx_bit;
      if (rx_st == S_DATA && rx_tick) rx_sh <= {rx_s2, rx_sh[7:1]};
    end
  always_comb begin
    status = '0;
    status[ST_RX_VALID] = !rx_empty;
    status[ST_TX_FULL] = tx_full;
    status[ST_TX_IDLE] = tx_empty && tx_st == S_IDLE;
    status[ST_RX_OVF] = rx_ovf;
    status[ST_FRAME_ERR] = frame_err;
    status[ST_TX_OVF] = tx_ovf;
    status[ST_BUSY] = tx_full;
  end
  assign rd_val = addr == A_DATA ? {23'b0, !rx_empty, rx_empty ? 8'h00 : rx_dout}
                : addr == A_STATUS ? status
                : addr == A_CTRL ? {29'b0, ctrl}
                : {16'(tx_count), 16'(rx_count)};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      ctrl <= '0;
      rx_ovf <= 1'b0;
      frame_err <= 1'b0;
      tx_ovf <= 1'b0;
      rdata <= '0;
      irq <= 1'b0;
    end else begin
      if (wr && addr == A_CTRL) ctrl <= ctrl_wr;
      rx_ovf <= (rx_push & rx_full & !rx_pop) | (rx_ovf & !(st_wr & wdata[ST_RX_OVF]));
      frame_err <= rx_ferr | (frame_err & !(st_wr & wdata[ST_FRAME_ERR]));
      tx_ovf <= (tx_push & tx_full & !tx_pop) | (tx_ovf & !(st_wr & wdata[ST_TX_OVF]));
      if (rd) rdata <= rd_val;
      irq <= (ctrl[CT_RX_IRQ] & !rx_empty) | (ctrl[CT_TX_IRQ] & tx_empty);
    end
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// tb_uart_mmio_fifo: directed self-checking bench for uart_mmio_fifo at DIV=8.
module tb_uart_mmio_fifo;
  logic clk = 1'b0, resetn = 1'b0, sel = 1'b0, rstrb = 1'b0, rxd = 1'b1;
  logic [1:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0] wmask = '0;
  logic [31:0] rdata;
  logic txd, irq;
  int n_cmp = 0, n_bad = 0;
`ifdef UART_LOOPBACK_EN
  localparam logic [31:0] CTRL7 = 32'h7;
`else
  localparam logic [31:0] CTRL7 = 32'h3;
`endif
  typedef struct {
    logic        do_wr;
    logic [1:0]  wa;
    logic [3:0]  wm;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[9];

  always #5 clk = ~clk;

  uart_mmio_fifo #(.CLK_FREQ_HZ(8), .BAUD_RATE(1), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .resetn(resetn), .sel(sel), .addr(addr), .wdata(wdata), .wmask(wmask),
    .rstrb(rstrb), .rdata(rdata), .txd(txd), .rxd(rxd), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m = 4'hf);
    @(negedge clk);
    sel = 1'b1; addr = a; wdata = d; wmask = m;
    @(negedge clk);
    sel = 1'b0; wmask = '0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    sel = 1'b1; rstrb = 1'b1; addr = a;
    @(negedge clk);
    sel = 1'b0; rstrb = 1'b0;
    check(name, rdata, exp);
  endtask

  task automatic expect_tx(input logic [7:0] exp, input string name);
    int t;
    logic [7:0] b;
    t = 0;
    while (txd === 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (txd !== 1'b0) begin
      check({name, " start timeout"}, {31'b0, txd}, 32'h0);
      return;
    end
    repeat (4) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      repeat (8) @(negedge clk);
      b[k] = txd;
    end
    repeat (8) @(negedge clk);
    check({name, " stop"}, {31'b0, txd}, 32'h1);
    check(name, {24'b0, b}, {24'b0, exp});
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rxd = b[k];
      repeat (8) @(negedge clk);
    end
    rxd = stop;
    repeat (8) @(negedge clk);
    rxd = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, t;
    logic [7:0] b;
    vt[0] = '{1'b0, 2'd0, 4'h0, 32'h0, 2'd1, 32'h004};
    vt[1] = '{1'b0, 2'd0, 4'h0, 32'h0, 2'd3, 32'h0};
    vt[2] = '{1'b0, 2'd0, 4'h0, 32'h0, 2'd2, 32'h0};
    vt[3] = '{1'b0, 2'd0, 4'h0, 32'h0, 2'd0, 32'h0};
    vt[4] = '{1'b1, 2'd2, 4'hf, 32'h7, 2'd2, CTRL7};
    vt[5] = '{1'b1, 2'd2, 4'he, 32'h0, 2'd2, CTRL7};
    vt[6] = '{1'b1, 2'd2, 4'h1, 32'h0, 2'd2, 32'h0};
    vt[7] = '{1'b1, 2'd1, 4'hf, 32'hffffffff, 2'd1, 32'h004};
    vt[8] = '{1'b1, 2'd3, 4'hf, 32'h0000ffff, 2'd3, 32'h0};
    #1;
    check("reset txd", {31'b0, txd}, 32'h1);
    check("reset irq", {31'b0, irq}, 32'h0);
    check("reset rdata", rdata, 32'h0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (vt[i].do_wr) wr(vt[i].wa, vt[i].wd, vt[i].wm);
      rd_chk($sformatf("vec%0d", i), vt[i].ra, vt[i].exp);
    end
    wr(2'd2, 32'h2);
    @(negedge clk);
    check("irq tx empty", {31'b0, irq}, 32'h1);
    wr(2'd2, 32'h0);
    @(negedge clk);
    check("irq off", {31'b0, irq}, 32'h0);

    // TX frame shape for 0x55
    wr(2'd0, 32'h55);
    t = 0;
    while (txd === 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n = 0;
    while (txd === 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tx start width", n, 8);
    repeat (3) @(negedge clk);
    b[0] = txd;
    for (int k = 1; k < 8; k++) begin
      repeat (8) @(negedge clk);
      b[k] = txd;
    end
    repeat (8) @(negedge clk);
    check("tx 0x55 stop", {31'b0, txd}, 32'h1);
    check("tx 0x55 byte", {24'b0, b}, 32'h55);
    repeat (6) @(negedge clk);
    rd_chk("tx idle", 2'd1, 32'h004);

    // TX FIFO overflow and in-order drain
    fork
      begin
        wr(2'd0, 32'h00);
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 17; i++) wr(2'd0, i);
        rd_chk("tx full status", 2'd1, 32'h222);
        rd_chk("tx level", 2'd3, 32'h0010_0000);
      end
      begin
        for (int i = 0; i <= 16; i++) expect_tx(i[7:0], $sformatf("tx byte %0d", i));
      end
    join
    repeat (10) @(negedge clk);
    rd_chk("tx drained status", 2'd1, 32'h024);
    wr(2'd1, 32'h20);
    rd_chk("tx_ovf cleared", 2'd1, 32'h004);

    // RX single frame and rx irq
    wr(2'd2, 32'h1);
    @(negedge clk);
    check("rx irq idle", {31'b0, irq}, 32'h0);
    send_rx(8'hA3, 1'b1);
    repeat (2) @(negedge clk);
    check("rx irq pending", {31'b0, irq}, 32'h1);
    rd_chk("rx data", 2'd0, 32'h1A3);
    @(negedge clk);
    check("rx irq cleared", {31'b0, irq}, 32'h0);
    rd_chk("rx empty read", 2'd0, 32'h0);
    wr(2'd2, 32'h0);

    // glitch and framing error
    @(negedge clk);
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    rd_chk("glitch level", 2'd3, 32'h0);
    send_rx(8'h5A, 1'b0);
    repeat (4) @(negedge clk);
    rd_chk("frame err status", 2'd1, 32'h014);
    rd_chk("frame err level", 2'd3, 32'h0);
    wr(2'd1, 32'h10);
    rd_chk("frame err cleared", 2'd1, 32'h004);

    // RX overflow
    for (int i = 0; i <= 16; i++) send_rx(i[7:0], 1'b1);
    repeat (4) @(negedge clk);
    rd_chk("rx ovf status", 2'd1, 32'h00D);
    rd_chk("rx full level", 2'd3, 32'h10);
    for (int i = 0; i < 16; i++) rd_chk($sformatf("rx read %0d", i), 2'd0, 32'h100 + i);
    rd_chk("rx drained status", 2'd1, 32'h00C);
    wr(2'd1, 32'h08);
    rd_chk("rx_ovf cleared", 2'd1, 32'h004);

    // reset mid-frame
    wr(2'd0, 32'h00);
    wr(2'd0, 32'h00);
    repeat (36) @(negedge clk);
    check("tx mid frame low", {31'b0, txd}, 32'h0);
    resetn = 1'b0;
    #1;
    check("async reset txd", {31'b0, txd}, 32'h1);
    check("async reset rdata", rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    rd_chk("post reset status", 2'd1, 32'h004);
    rd_chk("post reset level", 2'd3, 32'h0);
`ifdef UART_LOOPBACK_EN
    wr(2'd2, 32'h4);
    wr(2'd0, 32'h3C);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) n++;
    end
    check("loopback txd held", n, 0);
    rd_chk("loopback data", 2'd0, 32'h13C);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
